ramb_sp_param: RTL and testbench

Parametrised single-port synchronous block RAM with byte-granular write enables, selectable write mode and an optional output pipeline register. Adds a hardware clear sequencer that sweeps the array to a fill value after reset, with a BUSY flag, and a DO_VALID strobe that tracks read latency. It is the generic successor to the fixed-geometry 4-bit-wide RAM primitives and is instantiated wherever a user-sized on-chip buffer is needed.

---
 rtl/ramb_sp_param.sv | 172 +++++++++++++++++
 tb/tb_ramb_sp_param.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ramb_sp_param.sv
// ramb_sp_param: single-port synchronous block RAM with per-byte write enables,
// selectable write mode, optional output register and a post-reset clear sweep.
module ramb_sp_param #(
   parameter int unsigned           DATA_WIDTH     = 16,
   parameter int unsigned           BYTE_WIDTH     = 8,
   parameter int unsigned           ADDR_WIDTH     = 10,
   parameter string                 WRITE_MODE     = "WRITE_FIRST",
   parameter logic [DATA_WIDTH-1:0] INIT           = '0,
   parameter logic [DATA_WIDTH-1:0] SRVAL          = '0,
   parameter logic [DATA_WIDTH-1:0] FILL           = '0,
   parameter int unsigned           DO_REG         = 0,
   parameter int unsigned           CLEAR_ON_RESET = 1
) (
   input  logic                             CLK,
   input  logic                             SSR,
   input  logic                             EN,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] WE,
   input  logic [ADDR_WIDTH-1:0]            ADDR,
   input  logic [DATA_WIDTH-1:0]            DI,
   output logic [DATA_WIDTH-1:0]            DO,
   output logic                             DO_VALID,
   output logic                             BUSY
);

   localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
   localparam bit          MODE_WF   = (WRITE_MODE == "WRITE_FIRST");
   localparam bit          MODE_RF   = (WRITE_MODE == "READ_FIRST");
   localparam bit          MODE_NC   = (WRITE_MODE == "NO_CHANGE");

   // Reject unsupported configurations at elaboration
   if (!(MODE_WF || MODE_RF || MODE_NC)) begin : g_bad_mode
      $fatal(1, "ramb_sp_param: unsupported WRITE_MODE %s", WRITE_MODE);
   end
   if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
      $fatal(1, "ramb_sp_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t                  state_q = ST_READY;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q   = '0;
   logic [ADDR_WIDTH-1:0]   cnt_d;
   logic                    busy_q  = 1'b0;
   logic                    busy_d;
   logic [DATA_WIDTH-1:0]   latch_q = INIT;
   logic [DATA_WIDTH-1:0]   latch_d;
   logic                    dvld_q  = 1'b0;
   logic                    dvld_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH] = '{default: FILL};
   logic [NUM_BYTES-1:0]    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   merged;

   assign rd_word = mem_q[ADDR];

   // State register: SSR restarts the sweep (or goes straight to READY)
   always_ff @(posedge CLK) begin
      if (SSR) begin
         state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         cnt_q   <= '0;
         busy_q  <= (CLEAR_ON_RESET != 0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // Next state: sweep one address per cycle, leave CLEAR after the last word
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      if (state_q == ST_CLEAR) begin
         cnt_d = cnt_q + ADDR_WIDTH'(1);
         if (cnt_q == '1) begin
            state_d = ST_READY;
            busy_d  = 1'b0;
         end
      end
   end

   // Write-first view of the addressed word: new lanes from DI, others old
   always_comb begin
      merged = rd_word;
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
         if (WE[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = DI[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // Outputs: array write port and read latch control
   always_comb begin
      mem_we    = '0;
      mem_addr  = ADDR;
      mem_wdata = DI;
      latch_d   = latch_q;
      dvld_d    = 1'b0;
      if (!SSR) begin
         case (state_q)
            ST_CLEAR: begin
               mem_we    = '1;
               mem_addr  = cnt_q;
               mem_wdata = FILL;
            end
            ST_READY: begin
               if (EN) begin
                  mem_we = WE;
                  if (WE == '0) begin
                     latch_d = rd_word;
                     dvld_d  = 1'b1;
                  end else if (MODE_WF) begin
                     latch_d = merged;
                     dvld_d  = 1'b1;
                  end else if (MODE_RF) begin
                     latch_d = rd_word;
                     dvld_d  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Read latch and its valid bit
   always_ff @(posedge CLK) begin
      if (SSR) begin
         latch_q <= SRVAL;
         dvld_q  <= 1'b0;
      end else begin
         latch_q <= latch_d;
         dvld_q  <= dvld_d;
      end
   end

   // Array write port with per-lane enables; contents are never reset
   always_ff @(posedge CLK) begin
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
         if (mem_we[i]) mem_q[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   if (DO_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] oreg_q = INIT;
      logic                  ovld_q = 1'b0;

      // Output pipeline register with matching valid bit
      always_ff @(posedge CLK) begin
         if (SSR) begin
            oreg_q <= SRVAL;
            ovld_q <= 1'b0;
         end else begin
            oreg_q <= latch_q;
            ovld_q <= dvld_q;
         end
      end

      assign DO       = oreg_q;
      assign DO_VALID = ovld_q;
   end else begin : g_noreg
      assign DO       = latch_q;
      assign DO_VALID = dvld_q;
   end

   assign BUSY = busy_q;

endmodule

// File: tb/tb_ramb_sp_param.sv
// tb_ramb_sp_param: directed test of four RAM configurations driven in lockstep.
// Ordering of packed checks: {WRITE_FIRST, READ_FIRST, NO_CHANGE, WRITE_FIRST+DO_REG}.
module tb_ramb_sp_param;

   logic        clk = 1'b0;
   logic        ssr = 1'b0;
   logic        en  = 1'b0;
   logic [1:0]  we  = 2'b00;
   logic [3:0]  addr = '0;
   logic [15:0] di  = '0;

   logic [15:0] do_wf, do_rf, do_nc, do_dr;
   logic        v_wf, v_rf, v_nc, v_dr;
   logic        b_wf, b_rf, b_nc, b_dr;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   ramb_sp_param #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE("WRITE_FIRST"),
      .INIT(16'h5A5A), .SRVAL(16'h0F0F), .FILL(16'hA5A5), .DO_REG(0), .CLEAR_ON_RESET(1))
   u_wf (.CLK(clk), .SSR(ssr), .EN(en), .WE(we), .ADDR(addr), .DI(di),
         .DO(do_wf), .DO_VALID(v_wf), .BUSY(b_wf));

   ramb_sp_param #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE("READ_FIRST"),
      .INIT(16'h5A5A), .SRVAL(16'h0F0F), .FILL(16'hA5A5), .DO_REG(0), .CLEAR_ON_RESET(1))
   u_rf (.CLK(clk), .SSR(ssr), .EN(en), .WE(we), .ADDR(addr), .DI(di),
         .DO(do_rf), .DO_VALID(v_rf), .BUSY(b_rf));

   ramb_sp_param #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE("NO_CHANGE"),
      .INIT(16'h5A5A), .SRVAL(16'h0F0F), .FILL(16'hA5A5), .DO_REG(0), .CLEAR_ON_RESET(1))
   u_nc (.CLK(clk), .SSR(ssr), .EN(en), .WE(we), .ADDR(addr), .DI(di),
         .DO(do_nc), .DO_VALID(v_nc), .BUSY(b_nc));

   ramb_sp_param #(.DATA_WIDTH(16), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE("WRITE_FIRST"),
      .INIT(16'h5A5A), .SRVAL(16'h0F0F), .FILL(16'hA5A5), .DO_REG(1), .CLEAR_ON_RESET(1))
   u_dr (.CLK(clk), .SSR(ssr), .EN(en), .WE(we), .ADDR(addr), .DI(di),
         .DO(do_dr), .DO_VALID(v_dr), .BUSY(b_dr));

   // Advance one rising edge and settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare all four instances' DO, DO_VALID and BUSY against hand-derived values
   task automatic chk(input string tag, input logic [63:0] exp_do,
                      input logic [3:0] exp_v, input logic [3:0] exp_b);
      n_asserts++;
      assert ({do_wf, do_rf, do_nc, do_dr} === exp_do) else begin
         n_fail++;
         $error("FAIL %s DO observed=%h expected=%h", tag, {do_wf, do_rf, do_nc, do_dr}, exp_do);
      end
      n_asserts++;
      assert ({v_wf, v_rf, v_nc, v_dr} === exp_v) else begin
         n_fail++;
         $error("FAIL %s DO_VALID observed=%b expected=%b", tag, {v_wf, v_rf, v_nc, v_dr}, exp_v);
      end
      n_asserts++;
      assert ({b_wf, b_rf, b_nc, b_dr} === exp_b) else begin
         n_fail++;
         $error("FAIL %s BUSY observed=%b expected=%b", tag, {b_wf, b_rf, b_nc, b_dr}, exp_b);
      end
   endtask

   initial begin
      #1;
      chk("time_zero", {4{16'h5A5A}}, 4'b0000, 4'b0000);

      // Reset pulse, with a write attempt held on address 0 for the whole sweep
      ssr = 1'b1; en = 1'b1; we = 2'b11; addr = 4'd0; di = 16'hDEAD;
      tick();
      chk("reset", {4{16'h0F0F}}, 4'b0000, 4'b1111);
      ssr = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk($sformatf("sweep1_%0d", i), {4{16'h0F0F}}, 4'b0000, 4'b1111);
      end

      // Restart the sweep while it sits at address 8
      ssr = 1'b1;
      tick();
      chk("restart", {4{16'h0F0F}}, 4'b0000, 4'b1111);
      ssr = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         chk($sformatf("sweep2_%0d", i), {4{16'h0F0F}}, 4'b0000, 4'b1111);
      end
      tick();
      chk("sweep_done", {4{16'h0F0F}}, 4'b0000, 4'b0000);

      // Read back every address; DO_REG instance trails by one edge
      we = 2'b00;
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         tick();
         if (a == 0) chk("fill_rd_0", {{3{16'hA5A5}}, 16'h0F0F}, 4'b1110, 4'b0000);
         else        chk($sformatf("fill_rd_%0d", a), {4{16'hA5A5}}, 4'b1111, 4'b0000);
      end

      // EN low with WE set: no write, DO holds
      en = 1'b0; we = 2'b11; addr = 4'd7; di = 16'hFFFF;
      tick();
      chk("en_off_1", {4{16'hA5A5}}, 4'b0001, 4'b0000);
      tick();
      chk("en_off_2", {4{16'hA5A5}}, 4'b0000, 4'b0000);

      // Full-word write of 1234 to address 3
      en = 1'b1; we = 2'b11; addr = 4'd3; di = 16'h1234;
      tick();
      chk("wr3_full", {16'h1234, 16'hA5A5, 16'hA5A5, 16'hA5A5}, 4'b1100, 4'b0000);
      we = 2'b00;
      tick();
      chk("rd3_a", {4{16'h1234}}, 4'b1111, 4'b0000);

      // Write BEEF to address 5 (old content A5A5)
      we = 2'b11; addr = 4'd5; di = 16'hBEEF;
      tick();
      chk("wr5", {16'hBEEF, 16'hA5A5, 16'h1234, 16'h1234}, 4'b1101, 4'b0000);
      we = 2'b00;
      tick();
      chk("rd5", {4{16'hBEEF}}, 4'b1111, 4'b0000);

      // Low-lane write to address 3
      we = 2'b01; addr = 4'd3; di = 16'hFFCD;
      tick();
      chk("wr3_lo", {16'h12CD, 16'h1234, 16'hBEEF, 16'hBEEF}, 4'b1101, 4'b0000);
      we = 2'b00;
      tick();
      chk("rd3_b", {4{16'h12CD}}, 4'b1111, 4'b0000);

      // Address 7 was the target of the disabled write
      addr = 4'd7;
      tick();
      chk("rd7", {{3{16'hA5A5}}, 16'h12CD}, 4'b1111, 4'b0000);
      en = 1'b0;
      tick();
      chk("idle", {4{16'hA5A5}}, 4'b0001, 4'b0000);

      // SSR from READY reloads SRVAL and starts a new sweep
      ssr = 1'b1;
      tick();
      chk("reset2", {4{16'h0F0F}}, 4'b0000, 4'b1111);
      ssr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
